// File: rtl/iter_div_unit.sv
// Iterative restoring divider (signed/unsigned), BITS_PER_CYCLE quotient bits per cycle, with flush abort.
// Optional DIV_ZERO_FAST_EN: divide-by-zero retires from IDLE straight to DONE.
module iter_div_unit #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             signed_op_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);
  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             sop_q, sop_d, sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0] raw_q, raw_d, dsr_q, dsr_d, quo_q, quo_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] qo_q, qo_d, ro_q, ro_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] dvd_abs, dsr_abs, quo_step;
  logic [WIDTH:0]   rem_step;

  assign dvd_abs = (signed_op_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
  assign dsr_abs = (signed_op_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;

  // BITS_PER_CYCLE restoring sub-steps chained combinationally
  always_comb begin
    logic [WIDTH:0] diff;
    rem_step = rem_q;
    quo_step = quo_q;
    diff     = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      rem_step = {rem_step[WIDTH-1:0], quo_step[WIDTH-1]};
      quo_step = {quo_step[WIDTH-2:0], 1'b0};
      diff     = rem_step - {1'b0, dsr_q};
      if (!diff[WIDTH]) begin
        rem_step    = diff;
        quo_step[0] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      sop_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      raw_q   <= '0;
      dsr_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      qo_q    <= '0;
      ro_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sop_q   <= sop_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      raw_q   <= raw_d;
      dsr_q   <= dsr_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      qo_q    <= qo_d;
      ro_q    <= ro_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sop_d   = sop_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    raw_d   = raw_q;
    dsr_d   = dsr_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    qo_d    = qo_q;
    ro_d    = ro_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          sop_d   = signed_op_i;
          sa_d    = dividend_i[WIDTH-1];
          sb_d    = divisor_i[WIDTH-1];
          raw_d   = dividend_i;
          dsr_d   = dsr_abs;
          quo_d   = dvd_abs;
          rem_d   = '0;
          cnt_d   = CW'(N);
          state_d = S_CALC;
`ifdef DIV_ZERO_FAST_EN
          if (divisor_i == '0) begin
            qo_d    = '1;
            ro_d    = dividend_i;
            dz_d    = 1'b1;
            state_d = S_DONE;
          end
`else
`endif
        end
      end
      S_CALC: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          // zero divisor leaves |divisor| zero, so the raw-dividend override keys off dsr_q
          if (dsr_q == '0) begin
            qo_d = '1;
            ro_d = raw_q;
            dz_d = 1'b1;
          end else begin
            qo_d = (sop_q && (sa_q ^ sb_q)) ? -quo_q : quo_q;
            ro_d = (sop_q && sa_q) ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
            dz_d = 1'b0;
          end
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q != S_IDLE);
    done_o = (state_q == S_DONE);
  end

  assign quotient_o    = qo_q;
  assign remainder_o   = ro_q;
  assign div_by_zero_o = dz_q;
endmodule

// File: tb/tb_iter_div_unit.sv
// Scoreboarded directed test of iter_div_unit: radix-2 and radix-4 instances.
module tb_iter_div_unit;
  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          cyc;
  } exp_t;

`ifdef DIV_ZERO_FAST_EN
  localparam int DZ_LAT = 1;
`else
  localparam int DZ_LAT = 34;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st0 = 0, sop0 = 0, fl0 = 0, st1 = 0, sop1 = 0, fl1 = 0;
  logic [31:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic        busy0, done0, dz0, busy1, done1, dz1;
  logic [31:0] q0, r0, q1, r1;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  exp_t e0, e1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iter_div_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(st0), .signed_op_i(sop0),
    .dividend_i(a0), .divisor_i(b0), .flush_i(fl0), .busy_o(busy0),
    .done_o(done0), .quotient_o(q0), .remainder_o(r0), .div_by_zero_o(dz0)
  );

  iter_div_unit #(.WIDTH(32), .BITS_PER_CYCLE(2)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(st1), .signed_op_i(sop1),
    .dividend_i(a1), .divisor_i(b1), .flush_i(fl1), .busy_o(busy1),
    .done_o(done1), .quotient_o(q1), .remainder_o(r1), .div_by_zero_o(dz1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitors: pop one expected result per done pulse
  always @(negedge clk) begin
    if (done0) begin
      if (sb0.size() == 0) chk("u0_unexpected_done", 32'd1, 32'd0);
      else begin
        e0 = sb0.pop_front();
        chk("u0_quotient", q0, e0.q);
        chk("u0_remainder", r0, e0.r);
        chk("u0_dz", {31'd0, dz0}, {31'd0, e0.dz});
        chk("u0_done_cycle", cyc, e0.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (done1) begin
      if (sb1.size() == 0) chk("u1_unexpected_done", 32'd1, 32'd0);
      else begin
        e1 = sb1.pop_front();
        chk("u1_quotient", q1, e1.q);
        chk("u1_remainder", r1, e1.r);
        chk("u1_dz", {31'd0, dz1}, {31'd0, e1.dz});
        chk("u1_done_cycle", cyc, e1.cyc);
      end
    end
  end

  // called one time unit after a rising edge; lat = cycles from accept edge to done
  task automatic run_op(input bit w, input bit sop, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edz,
                        input int lat, input string nm);
    exp_t e;
    e.q = eq; e.r = er; e.dz = edz; e.cyc = cyc + lat;
    if (w) begin sb1.push_back(e); st1 = 1; sop1 = sop; a1 = a; b1 = b; end
    else   begin sb0.push_back(e); st0 = 1; sop0 = sop; a0 = a; b0 = b; end
    @(posedge clk); #1;
    st0 = 0; st1 = 0;
    chk({nm, "_busy_after_start"}, {31'd0, w ? busy1 : busy0}, 32'd1);
    repeat (lat) @(posedge clk);
    #1;
    chk({nm, "_idle_after_done"}, {31'd0, w ? busy1 : busy0}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    exp_t e;
    #2;
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_done", {31'd0, done0}, 32'd0);
    chk("rst_q", q0, 32'd0);
    chk("rst_r", r0, 32'd0);
    chk("rst_dz", {31'd0, dz0}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;

    run_op(0, 0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 34, "u100_7");
    run_op(0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 34, "sm7_2");
    run_op(0, 1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 0, 34, "s7_m2");
    run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0, 34, "s_ovf");
    run_op(0, 0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1, DZ_LAT, "u5_0");
    run_op(0, 1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1, DZ_LAT, "sm5_0");

    // flush in cycle 10 of an operation: no done, outputs held
    st0 = 1; sop0 = 0; a0 = 32'd100; b0 = 32'd7;
    @(posedge clk); #1;
    st0 = 0;
    repeat (9) @(posedge clk);
    #1;
    fl0 = 1;
    @(posedge clk); #1;
    fl0 = 0;
    chk("flush_busy", {31'd0, busy0}, 32'd0);
    chk("flush_hold_q", q0, 32'hFFFF_FFFF);
    chk("flush_hold_r", r0, 32'hFFFF_FFFB);
    chk("flush_hold_dz", {31'd0, dz0}, 32'd1);
    run_op(0, 0, 32'd9, 32'd3, 32'd3, 32'd0, 0, 34, "u9_3_after_flush");

    // start while busy is ignored
    e.q = 32'd5; e.r = 32'd0; e.dz = 0; e.cyc = cyc + 34;
    sb0.push_back(e);
    st0 = 1; sop0 = 0; a0 = 32'd20; b0 = 32'd4;
    @(posedge clk); #1;
    st0 = 0;
    repeat (4) @(posedge clk);
    #1;
    st0 = 1; a0 = 32'd1; b0 = 32'd1;
    @(posedge clk); #1;
    st0 = 0;
    repeat (29) @(posedge clk);
    #1;
    chk("busy_start_ignored_idle", {31'd0, busy0}, 32'd0);

    // flush wins over start in IDLE
    st0 = 1; fl0 = 1; a0 = 32'd50; b0 = 32'd5;
    @(posedge clk); #1;
    st0 = 0; fl0 = 0;
    chk("idle_flush_busy", {31'd0, busy0}, 32'd0);

    // asynchronous reset mid-operation
    st0 = 1; sop0 = 0; a0 = 32'd100; b0 = 32'd7;
    @(posedge clk); #1;
    st0 = 0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    chk("arst_busy", {31'd0, busy0}, 32'd0);
    chk("arst_q", q0, 32'd0);
    chk("arst_r", r0, 32'd0);
    chk("arst_dz", {31'd0, dz0}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    run_op(0, 0, 32'd9, 32'd3, 32'd3, 32'd0, 0, 34, "u9_3_after_rst");

    // radix-4 instance
    run_op(1, 0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 0, 18, "r4_ffff_10");
    run_op(1, 0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 18, "r4_100_7");
    run_op(1, 1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 0, 18, "r4_sm100_7");

    repeat (3) @(posedge clk);
    #1;
    chk("u0_pending", sb0.size(), 32'd0);
    chk("u1_pending", sb1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/iter_div_unit.md
# iter_div_unit

Parametrised iterative integer divider for the execute stage, the successor to the fixed 32-bit divider behind the ALU's DIV.W/MOD.W/DIV.WU/MOD.WU path. It takes one signed or unsigned division per start pulse and retires BITS_PER_CYCLE quotient bits per cycle. Unlike the previous divider, it adds:
- an explicit flush abort;
- defined divide-by-zero results with a flag;
- configurable width and radix.

The ALU drives `start` and holds the pipeline while `busy` is high.

## Interface
- WIDTH, 32, operand/result width in bits; even, ≥ 4.
- BITS_PER_CYCLE, 1, quotient bits resolved per CALC cycle; 1 or 2; must divide WIDTH.
- clk  input  1  clock, rising edge.
- rst  input  1  reset; one clock; reset is asynchronous and active-low (asserted at 0).
- start  input  1  request; sampled only in IDLE.
- signed_op  input  1  1 = two's-complement division, 0 = unsigned; sampled with start.
- dividend  input  WIDTH  sampled with start.
- divisor  input  WIDTH  sampled with start.
- flush  input  1  abort the current operation (pipeline flush).
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse; results valid in that cycle.
- quotient  output  WIDTH  held from done until the next accepted start.
- remainder  output  WIDTH  held from done until the next accepted start.
- div_by_zero  output  1  registered with the results; divisor was 0.

## Operation
- States: IDLE, CALC, FIX, DONE.
- **IDLE.**
  - start=1 and flush=0: latch signed_op, the operand signs (sa, sb), |dividend| and |divisor| (absolute value only when signed_op), and the raw dividend.
  - Clear the partial remainder (WIDTH+1 bits) and load the iteration counter with N = WIDTH/BITS_PER_CYCLE.
  - Go to CALC.
- **CALC.**
  - Restoring division: per sub-step, shift {rem, quo} left 1, trial-subtract |divisor|, keep the result if non-negative and set the quotient LSB.
  - BITS_PER_CYCLE sub-steps are chained combinationally per cycle.
  - Counter decrements; at 0 go to FIX.
- **FIX.**
  - Sign correction: quotient negated iff signed_op & (sa ^ sb); remainder negated iff signed_op & sa.
  - Divisor == 0 overrides: quotient = all ones, remainder = raw dividend, div_by_zero = 1.
  - Results are registered into the output registers; go to DONE.
- **DONE.** done=1 for this cycle only; go to IDLE.
- Signed overflow (most-negative / −1): quotient = most-negative value, remainder = 0. This falls out of the unsigned magnitude path and needs no special case.
- All arithmetic is modulo 2^WIDTH. Magnitudes are computed as unsigned WIDTH-bit values, so |most-negative| is representable.
- Outputs are not updated on abort; the previous results stay visible.

## Timing
- Reset (rst=0, asynchronous): state=IDLE; busy, done, quotient, remainder, div_by_zero all 0; counter 0.
- Start accepted at edge of cycle 0:
  - busy=1 from cycle 1;
  - CALC occupies cycles 1..N;
  - FIX is cycle N+1;
  - done=1 in cycle N+2;
  - busy=0 from cycle N+3.
- Latency N+2 (34 for the defaults). A new start is accepted in cycle N+3.
- start while busy: ignored, with no queuing. The ALU must keep start asserted or re-issue it.
- flush=1 in any state other than IDLE: next state IDLE, no done, outputs unchanged.
- flush=1 in IDLE with start=1: flush wins and start is ignored.
- flush in the DONE cycle: done still pulses in that cycle; the state returns to IDLE as normal.
- Reset mid-operation: immediate return to IDLE; no done is produced after release.

## Configuration
- DIV_ZERO_FAST_EN defined:
  - In IDLE, start with divisor == 0 bypasses CALC and FIX.
  - Results (quotient all ones, remainder = dividend, div_by_zero = 1) are registered at the accept edge.
  - DONE occurs in cycle 1, so done=1 in cycle 1 and busy=1 only in cycle 1.
- DIV_ZERO_FAST_EN undefined: divide-by-zero runs the full N+2 latency and produces identical result values.

## Test plan
- Unsigned 100 / 7, WIDTH=32, BITS_PER_CYCLE=1 -> done in cycle 34 with quotient=14, remainder=2, div_by_zero=0; busy=0 in cycle 35.
- Signed −7 / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0.
- Unsigned 5 / 0 -> quotient=0xFFFFFFFF, remainder=5, div_by_zero=1.
  - With DIV_ZERO_FAST_EN: done in cycle 1.
  - Without DIV_ZERO_FAST_EN: done in cycle 34.
- Start 100 / 7, then flush=1 in cycle 10 -> busy=0 in cycle 11, done never pulses, outputs keep their prior values.
  - Then start 9 / 3 in cycle 11 -> done in cycle 45 with quotient=3, remainder=0.
- BITS_PER_CYCLE=2, unsigned 0xFFFFFFFF / 0x10 -> done in cycle 18, quotient=0x0FFFFFFF, remainder=0xF.
- rst=0 pulse in cycle 5 of an operation -> all outputs 0 asynchronously, no done after release; a new start is accepted immediately.
